// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg : shared encodings for the MIPS single- and multi-cycle control
// Optional: MULTICYCLE_CONTROL_JUMP_EN makes OP_J a supported opcode.  Rev 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    ok = ok || (op == OP_J);
`endif
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_out.sv
// ============================================================================
// multicycle_control_out : combinational decode of state/ready/opcode to strobes
// Optional: MULTICYCLE_CONTROL_JUMP_EN enables JUMP state outputs.      Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_control_out
  import mips_ctrl_pkg::*;
(
  input  logic       rst_i,
  input  state_e     state_i,
  input  logic       mem_ready_i,
  input  logic [5:0] opcode_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_B;
    alu_op_o        = ALU_ADD;
    pc_source_o     = PCSRC_ALU;
    instr_done_o    = 1'b0;
    illegal_o       = 1'b0;

    // Reset masks every strobe but presents the FETCH selects.
    if (rst_i) begin
      alu_src_b_o = SRCB_FOUR;
    end else begin
      case (state_i)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SRCB_FOUR;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = SRCB_IMM_SH2;
          illegal_o   = ~op_supported(opcode_i);
        end
        S_MEMADR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_MEMWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEMWR: begin
          mem_write_o  = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_REXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_FUNCT;
        end
        S_RWB: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 1'b1;
          instr_done_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = ALU_SUB;
          pc_write_cond_o = 1'b1;
          pc_source_o     = PCSRC_ALUOUT;
          instr_done_o    = 1'b1;
        end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        S_JUMP: begin
          pc_write_o   = 1'b1;
          pc_source_o  = PCSRC_JUMP;
          instr_done_o = 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : multi-cycle MIPS controller, state register + next state
// Optional: MULTICYCLE_CONTROL_JUMP_EN adds the j instruction.          Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         opcode_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               mem_to_reg_o,
  output logic               reg_dst_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic [1:0]         pc_source_o,
  output logic               instr_done_o,
  output logic               illegal_o,
  output logic [STATE_W-1:0] state_o
);

  state_e state_q, state_d;
  // Opcode is only valid in DECODE, so the lw/sw split after MEMADR is remembered here.
  logic   is_sw_q, is_sw_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_sw_d = is_sw_q;
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        is_sw_d = (opcode_i == OP_SW);
        case (opcode_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  assign state_o = rst_i ? '0 : STATE_W'(state_q);

  multicycle_control_out u_out (
    .rst_i           (rst_i),
    .state_i         (state_q),
    .mem_ready_i     (mem_ready_i),
    .opcode_i        (opcode_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .iord_o          (iord_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_dst_o       (reg_dst_o),
    .reg_write_o     (reg_write_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .pc_source_o     (pc_source_o),
    .instr_done_o    (instr_done_o),
    .illegal_o       (illegal_o)
  );

endmodule

`default_nettype wire
